// File: rtl/chunked_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
// Compile-time option CHUNKED_ADDSUB_CIN_EN adds a carry/borrow-in port (see chunked_addsub.sv).
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions of the packed flag register
  localparam int FLAG_CF   = 0;
  localparam int FLAG_ZF   = 1;
  localparam int FLAG_SF   = 2;
  localparam int FLAG_OF   = 3;
  localparam int NUM_FLAGS = 4;

  // Number of chunk steps per operation; guarded so a bad CHUNK cannot divide by zero
  function automatic int num_chunks(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  // Chunk index width, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Operand/result handshake bundle for chunked_addsub.
// With CHUNKED_ADDSUB_CIN_EN defined the bundle also carries cin.
interface chunked_addsub_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cf;
  logic             zf;
  logic             sf;
  logic             of;

`ifdef CHUNKED_ADDSUB_CIN_EN
  logic             cin;

  modport master (
    output in_valid, sub, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cf, zf, sf, of
  );

  modport slave (
    input  in_valid, sub, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cf, zf, sf, of
  );
`else
  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cf, zf, sf, of
  );

  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, cf, zf, sf, of
  );
`endif

endinterface

// File: rtl/chunked_addsub_chunk_ripple_adder.sv
// CHUNK-bit ripple-carry adder built from explicit full-adder cells.
// One instance is reused every cycle by chunked_addsub.
module chunk_ripple_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  // Each cell keeps its own carry wire so the chain is not one self-referencing vector
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic w_ci;
    logic w_co;
    logic w_p;

    if (i == 0) begin : g_first
      assign w_ci = i_cin;
    end else begin : g_next
      assign w_ci = g_bit[i-1].w_co;
    end

    assign w_p      = i_a[i] ^ i_b[i];
    assign o_sum[i] = w_p ^ w_ci;
    assign w_co     = (i_a[i] & i_b[i]) | (w_p & w_ci);
  end

  assign o_cout = g_bit[CHUNK-1].w_co;

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle through a registered carry,
// with CF/ZF/SF/OF. Define CHUNKED_ADDSUB_CIN_EN to add a carry/borrow-in input (bus.cin).
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic             clk,
  input logic             rst_n,
  chunked_addsub_if.slave bus
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_addsub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_e               r_state;
  state_e               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_sub;
  logic                 r_carry;
  logic [IW-1:0]        r_idx;
  logic [NUM_FLAGS-1:0] r_flags;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_init_carry;
  logic [CHUNK-1:0]     w_a_chunk;
  logic [CHUNK-1:0]     w_b_chunk;
  logic [CHUNK-1:0]     w_chunk_sum;
  logic                 w_chunk_cout;
  logic [WIDTH-1:0]     w_acc_next;
  logic [NUM_FLAGS-1:0] w_flags_next;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IW'(N - 1));

`ifdef CHUNKED_ADDSUB_CIN_EN
  // In subtract mode cin is a borrow-in, which inverts into the two's-complement carry
  assign w_init_carry = bus.sub ? ~bus.cin : bus.cin;
`else
  assign w_init_carry = bus.sub;
`endif

  assign w_a_chunk = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_b_chunk = r_b[int'(r_idx) * CHUNK +: CHUNK];

  chunk_ripple_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_idx) * CHUNK +: CHUNK] = w_chunk_sum;
  end

  // Only meaningful on the last chunk, when w_chunk_cout is the final carry-out
  always_comb begin
    w_flags_next          = '0;
    w_flags_next[FLAG_CF] = w_chunk_cout ^ r_sub;
    w_flags_next[FLAG_ZF] = (w_acc_next == '0);
    w_flags_next[FLAG_SF] = w_acc_next[WIDTH-1];
    w_flags_next[FLAG_OF] = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                            (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the simulated order of always_ff blocks cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // r_acc builds the new result chunk by chunk; r_sum keeps the previous result until
  // the last chunk lands, so the output never shows a half-finished value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_sub   <= bus.sub;
            r_carry <= w_init_carry;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_chunk_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_flags <= w_flags_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cf        = r_flags[FLAG_CF];
  assign bus.zf        = r_flags[FLAG_ZF];
  assign bus.sf        = r_flags[FLAG_SF];
  assign bus.of        = r_flags[FLAG_OF];

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: a CHUNK=16 and a CHUNK=64 instance share one stimulus stream.
// Hand vectors, randomized ops against an arithmetic model, backpressure and mid-op reset.
module tb_chunked_addsub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(64)) bus  ();
  chunked_addsub_if #(.WIDTH(64)) bus1 ();

  chunked_addsub #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  chunked_addsub #(.WIDTH(64), .CHUNK(64)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus1.in_valid  = bus.in_valid;
  assign bus1.sub       = bus.sub;
  assign bus1.a         = bus.a;
  assign bus1.b         = bus.b;
  assign bus1.out_ready = bus.out_ready;
`ifdef CHUNKED_ADDSUB_CIN_EN
  assign bus1.cin       = bus.cin;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic [3:0]  flags;   // {cf, zf, sf, of}
  } vec_t;

  // Reference: exact integer arithmetic, wider than the operands
  function automatic logic [67:0] ref_model(input logic s, input logic [63:0] x,
                                            input logic [63:0] y, input logic c);
    logic [64:0]        t;
    logic signed [65:0] ex;
    logic signed [65:0] sx;
    logic signed [65:0] sy;
    logic signed [65:0] sc;
    logic [3:0]         f;
    sx = $signed({x[63], x[63], x});
    sy = $signed({y[63], y[63], y});
    sc = $signed({65'd0, c});
    if (!s) begin
      t  = {1'b0, x} + {1'b0, y} + {64'd0, c};
      ex = sx + sy + sc;
    end else begin
      t  = {1'b0, x} - {1'b0, y} - {64'd0, c};
      ex = sx - sy - sc;
    end
    f[3] = t[64];
    f[2] = (t[63:0] == 64'd0);
    f[1] = t[63];
    f[0] = !((ex[65] == ex[63]) && (ex[64] == ex[63]));
    return {f, t[63:0]};
  endfunction

  function automatic logic [3:0] flags16();
    return {bus.cf, bus.zf, bus.sf, bus.of};
  endfunction

  function automatic logic [3:0] flags64();
    return {bus1.cf, bus1.zf, bus1.sf, bus1.of};
  endfunction

  // Called and returns at a falling edge with both DUTs idle
  task automatic run_op(input string tag, input logic s, input logic [63:0] x,
                        input logic [63:0] y, input logic c,
                        input logic [63:0] exp_sum, input logic [3:0] exp_flags);
    int l16 = -1;
    int l64 = -1;
    check({tag, " in_ready before"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.sub      = s;
    bus.a        = x;
    bus.b        = y;
`ifdef CHUNKED_ADDSUB_CIN_EN
    bus.cin      = c;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~x;
    bus.b        = ~y;
    for (int cyc = 1; cyc <= 20 && l16 < 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (l64 < 0 && bus1.out_valid) l64 = cyc;
      if (bus.out_valid) l16 = cyc;
    end
    check({tag, " latency c16"}, 64'(l16), 64'd4);
    check({tag, " latency c64"}, 64'(l64), 64'd1);
    check({tag, " in_ready busy"}, bus.in_ready, 0);
    check({tag, " sum c16"}, bus.sum, exp_sum);
    check({tag, " flags c16"}, flags16(), exp_flags);
    check({tag, " sum c64"}, bus1.sum, exp_sum);
    check({tag, " flags c64"}, flags64(), exp_flags);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " out_valid after xfer"}, {bus.out_valid, bus1.out_valid}, 2'b00);
    check({tag, " in_ready after xfer"}, {bus.in_ready, bus1.in_ready}, 2'b11);
    check({tag, " sum held after xfer"}, bus.sum, exp_sum);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [67:0] r;
    logic        s;
    logic        c;
    logic [63:0] x;
    logic [63:0] y;

    tbl[0] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0011};
    tbl[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,                  4'b1100};
    tbl[2] = '{1'b1, 64'd5,                  64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
    tbl[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001};
    tbl[4] = '{1'b1, 64'd7,                  64'd7, 1'b0, 64'd0,                  4'b0100};
    tbl[5] = '{1'b0, 64'd0,                  64'd0, 1'b0, 64'd0,                  4'b0100};
    tbl[6] = '{1'b1, 64'd0,                  64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010};
    tbl[7] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 4'b0000};

    bus.in_valid  = 1'b0;
    bus.sub       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
`ifdef CHUNKED_ADDSUB_CIN_EN
    bus.cin       = 1'b0;
`endif

    // Reset state, both while held and just after release
    repeat (2) @(negedge clk);
    check("reset in_ready", {bus.in_ready, bus1.in_ready}, 2'b11);
    check("reset out_valid", {bus.out_valid, bus1.out_valid}, 2'b00);
    check("reset sum", bus.sum | bus1.sum, 64'd0);
    check("reset flags", {flags16(), flags64()}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle out_valid", {bus.out_valid, bus1.out_valid}, 2'b00);
    check("idle in_ready", {bus.in_ready, bus1.in_ready}, 2'b11);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].sum, tbl[i].flags);
    end

`ifdef CHUNKED_ADDSUB_CIN_EN
    run_op("cin add 1+1+1", 1'b0, 64'd1, 64'd1, 1'b1, 64'd3, 4'b0000);
    run_op("cin sub 5-3-1", 1'b1, 64'd5, 64'd3, 1'b1, 64'd1, 4'b0000);
    run_op("cin sub 0-0-1", 1'b1, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
    run_op("cin add max+0+1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b1100);
`endif

    for (int i = 0; i < 24; i++) begin
      s = 1'(($urandom() >> 3) & 1);
      x = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = ~x;
        2:       y = {32'($urandom() & 1) << 31, 32'd0} ^ 64'hFFFF;
        default: y = {$urandom(), $urandom()};
      endcase
`ifdef CHUNKED_ADDSUB_CIN_EN
      c = 1'(($urandom() >> 5) & 1);
`else
      c = 1'b0;
`endif
      r = ref_model(s, x, y, c);
      run_op($sformatf("rand%0d", i), s, x, y, c, r[63:0], r[67:64]);
    end

    // Backpressure: result held for 5 stalled cycles, waiting operands ignored until IDLE
    bus.in_valid = 1'b1;
    bus.sub      = 1'b1;
    bus.a        = 64'd100;
    bus.b        = 64'd23;
`ifdef CHUNKED_ADDSUB_CIN_EN
    bus.cin      = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.sub = 1'b0;
    bus.a   = 64'd555;
    bus.b   = 64'd1;
    for (int cyc = 1; cyc <= 20 && !bus.out_valid; cyc++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp out_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp stall%0d sum", i), bus.sum, 64'd77);
      check($sformatf("bp stall%0d valid/ready", i), {bus.out_valid, bus.in_ready}, 2'b10);
      check($sformatf("bp stall%0d c64 sum", i), bus1.sum, 64'd77);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp idle valid/ready", {bus.out_valid, bus.in_ready}, 2'b01);
    check("bp idle sum", bus.sum, 64'd77);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp second accepted", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp run%0d old sum kept", i), bus.sum, 64'd77);
      check($sformatf("bp run%0d out_valid", i), bus.out_valid, 0);
    end
    @(posedge clk);
    @(negedge clk);
    check("bp second out_valid", bus.out_valid, 1);
    check("bp second sum", bus.sum, 64'd556);
    check("bp second flags", flags16(), 4'b0000);
    check("bp second c64 sum", bus1.sum, 64'd556);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the second RUN cycle
    bus.in_valid = 1'b1;
    bus.sub      = 1'b0;
    bus.a        = 64'd3;
    bus.b        = 64'd4;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", {bus.out_valid, bus1.out_valid}, 2'b00);
    check("mid-run reset in_ready", {bus.in_ready, bus1.in_ready}, 2'b11);
    check("mid-run reset sum", bus.sum | bus1.sum, 64'd0);
    check("mid-run reset flags", {flags16(), flags64()}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post-reset", 1'b0, 64'd9, 64'd4, 1'b0, 64'd13, 4'b0000);
    run_op("post-reset sub", 1'b1, 64'h0001_0000_0000_0000, 64'd1, 1'b0,
           64'h0000_FFFF_FFFF_FFFF, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
